// File: rtl/rotary_quad_filter.sv
// Rotary encoder front end: 2-FF synchroniser, joint debounce of the {a,b} pair,
// and a quadrature FSM that emits one rot_event per completed detent cycle.
module rotary_quad_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic rot_a,
  input  logic rot_b,
  output logic rot_event,
  output logic rot_dir,
  output logic rot_err
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_CW1,
    S_CW2,
    S_CW3,
    S_CCW1,
    S_CCW2,
    S_CCW3
  } state_t;

  logic [1:0]       a_ff, b_ff;
  logic [1:0]       sync, sync_prev, filt;
  logic             filt_valid;
  logic [CNT_W-1:0] cnt, cnt_run;

  state_t     state, state_nxt;
  logic [1:0] state_phase;
  logic       event_nxt, err_nxt, dir_nxt;

  assign sync = {a_ff[1], b_ff[1]};

  // A fresh sample value starts a new stability run at zero.
  always_comb cnt_run = (sync != sync_prev) ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ff       <= '0;
      b_ff       <= '0;
      sync_prev  <= '0;
      filt       <= '0;
      filt_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      a_ff      <= {a_ff[0], rot_a};
      b_ff      <= {b_ff[0], rot_b};
      sync_prev <= sync;
      if (filt_valid && sync == filt) begin
        cnt <= '0;
      end else if (cnt_run == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt       <= sync;
        filt_valid <= 1'b1;
        cnt        <= '0;
      end else begin
        cnt <= cnt_run + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_phase = 2'b00;
    case (state)
      S_CW1, S_CCW3: state_phase = 2'b10;
      S_CW2, S_CCW2: state_phase = 2'b11;
      S_CW3, S_CCW1: state_phase = 2'b01;
      default:       state_phase = 2'b00;
    endcase
  end

  // Each non-WAIT state owns one phase; filt differing in one bit moves to a
  // neighbour, differing in both bits is an illegal jump.
  always_comb begin
    state_nxt = state;
    event_nxt = 1'b0;
    err_nxt   = 1'b0;
    dir_nxt   = rot_dir;
    if (state == S_WAIT) begin
      if (filt_valid && filt == 2'b00) state_nxt = S_IDLE;
    end else if (filt != state_phase) begin
      if ((filt ^ state_phase) == 2'b11) begin
        state_nxt = S_WAIT;
        err_nxt   = 1'b1;
      end else begin
        case (state)
          S_IDLE: state_nxt = (filt == 2'b10) ? S_CW1 : S_CCW1;
          S_CW1:  state_nxt = (filt == 2'b11) ? S_CW2 : S_IDLE;
          S_CW2:  state_nxt = (filt == 2'b01) ? S_CW3 : S_CW1;
          S_CW3: begin
            if (filt == 2'b00) begin
              state_nxt = S_IDLE;
              event_nxt = 1'b1;
              dir_nxt   = 1'b1;
            end else begin
              state_nxt = S_CW2;
            end
          end
          S_CCW1: state_nxt = (filt == 2'b11) ? S_CCW2 : S_IDLE;
          S_CCW2: state_nxt = (filt == 2'b10) ? S_CCW3 : S_CCW1;
          S_CCW3: begin
            if (filt == 2'b00) begin
              state_nxt = S_IDLE;
              event_nxt = 1'b1;
              dir_nxt   = 1'b0;
            end else begin
              state_nxt = S_CCW2;
            end
          end
          default: state_nxt = S_WAIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT;
      rot_event <= 1'b0;
      rot_err   <= 1'b0;
      rot_dir   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rot_event <= event_nxt;
      rot_err   <= err_nxt;
      rot_dir   <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_rotary_quad_filter.sv
// Directed self-checking bench for rotary_quad_filter with DEBOUNCE_CYCLES=4.
module tb_rotary_quad_filter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rot_a = 1'b0;
  logic rot_b = 1'b0;
  logic rot_event, rot_dir, rot_err;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic last_ev_dir = 1'b0;

  rotary_quad_filter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rot_a     (rot_a),
    .rot_b     (rot_b),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .rot_err   (rot_err)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled mid-cycle so each one-cycle pulse is seen once.
  always @(negedge clk) begin
    if (rot_event === 1'b1) begin
      ev_cnt++;
      last_ev_dir = rot_dir;
    end
    if (rot_err === 1'b1) err_cnt++;
    if (rot_event === 1'b1 && rot_err === 1'b1) both_cnt++;
  end

  task automatic hold(input logic a, input logic b, input int n);
    @(negedge clk);
    rot_a = a;
    rot_b = b;
    repeat (n) @(posedge clk);
  endtask

  task automatic run_cw(input int n);
    hold(1'b0, 1'b0, n);
    hold(1'b1, 1'b0, n);
    hold(1'b1, 1'b1, n);
    hold(1'b0, 1'b1, n);
    hold(1'b0, 1'b0, n);
  endtask

  task automatic run_ccw(input int n);
    hold(1'b0, 1'b0, n);
    hold(1'b0, 1'b1, n);
    hold(1'b1, 1'b1, n);
    hold(1'b1, 1'b0, n);
    hold(1'b0, 1'b0, n);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    rot_a = 1'b0;
    rot_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rot_event !== 1'b0) begin errors++; $display("FAIL reset_event got=%b exp=0", rot_event); end
    checks++; if (rot_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rot_err); end
    checks++; if (rot_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", rot_dir); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle;
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL idle_events got=%0d exp=0", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL idle_errs got=%0d exp=0", err_cnt - r0); end
    checks++; if (rot_dir !== 1'b0) begin errors++; $display("FAIL idle_dir got=%b exp=0", rot_dir); end
    checks++; if (dut.filt_valid !== 1'b1) begin errors++; $display("FAIL idle_filt_valid got=%b exp=1", dut.filt_valid); end
  endtask

  task automatic test_cw_latency;
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    @(negedge clk);
    rot_a = 1'b0;
    rot_b = 1'b0;
    @(posedge clk);               // edge N
    repeat (5) @(posedge clk);    // edge N+5
    #1;
    checks++; if (rot_event !== 1'b0) begin errors++; $display("FAIL cw_early_event got=%b exp=0", rot_event); end
    @(posedge clk);               // edge N+6
    #1;
    checks++; if (rot_event !== 1'b1) begin errors++; $display("FAIL cw_event_n6 got=%b exp=1", rot_event); end
    checks++; if (rot_dir !== 1'b1) begin errors++; $display("FAIL cw_dir got=%b exp=1", rot_dir); end
    @(posedge clk);
    #1;
    checks++; if (rot_event !== 1'b0) begin errors++; $display("FAIL cw_pulse_width got=%b exp=0", rot_event); end
    repeat (8) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL cw_event_count got=%0d exp=1", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL cw_errs got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_ccw_cw_ccw;
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    run_ccw(10);
    repeat (4) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL seq1_count got=%0d exp=1", ev_cnt - e0); end
    checks++; if (last_ev_dir !== 1'b0) begin errors++; $display("FAIL seq1_dir got=%b exp=0", last_ev_dir); end
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    #1;
    checks++; if (rot_dir !== 1'b0) begin errors++; $display("FAIL seq2_dir_held got=%b exp=0", rot_dir); end
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    repeat (4) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 2) begin errors++; $display("FAIL seq2_count got=%0d exp=2", ev_cnt - e0); end
    checks++; if (last_ev_dir !== 1'b1) begin errors++; $display("FAIL seq2_dir got=%b exp=1", last_ev_dir); end
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    #1;
    checks++; if (rot_dir !== 1'b1) begin errors++; $display("FAIL seq3_dir_held got=%b exp=1", rot_dir); end
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    repeat (4) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 3) begin errors++; $display("FAIL seq3_count got=%0d exp=3", ev_cnt - e0); end
    checks++; if (last_ev_dir !== 1'b0) begin errors++; $display("FAIL seq3_dir got=%b exp=0", last_ev_dir); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL seq_errs got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_bounce;
    int e0, r0, bad;
    e0 = ev_cnt;
    r0 = err_cnt;
    bad = 0;
    @(negedge clk); rot_a = 1'b1;
    @(negedge clk); rot_a = 1'b0;
    @(negedge clk); rot_a = 1'b1;
    @(negedge clk); rot_a = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (dut.filt !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bounce_filt_moved got=%0d exp=0 cycles", bad); end
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL bounce_events got=%0d exp=0", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL bounce_errs got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_partial_and_jump;
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL partial_events got=%0d exp=0", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL partial_errs got=%0d exp=0", err_cnt - r0); end
    hold(1'b1, 1'b1, 10);
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL jump_err_count got=%0d exp=1", err_cnt - r0); end
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL jump_events got=%0d exp=0", ev_cnt - e0); end
    run_cw(10);
    repeat (4) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL recover_events got=%0d exp=1", ev_cnt - e0); end
    checks++; if (last_ev_dir !== 1'b1) begin errors++; $display("FAIL recover_dir got=%b exp=1", last_ev_dir); end
    checks++; if (err_cnt - r0 !== 1) begin errors++; $display("FAIL recover_errs got=%0d exp=1", err_cnt - r0); end
  endtask

  task automatic test_back_to_back;
    int e0, r0;
    e0 = ev_cnt;
    r0 = err_cnt;
    run_cw(5);
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 5);
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 8);
    checks++; if (ev_cnt - e0 !== 2) begin errors++; $display("FAIL b2b_events got=%0d exp=2", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL b2b_errs got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    int e0, r0;
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    e0 = ev_cnt;
    r0 = err_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rot_event !== 1'b0) begin errors++; $display("FAIL midrst_event got=%b exp=0", rot_event); end
    checks++; if (rot_err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", rot_err); end
    checks++; if (rot_dir !== 1'b0) begin errors++; $display("FAIL midrst_dir got=%b exp=0", rot_dir); end
    @(negedge clk);
    reset = 1'b0;
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    checks++; if (ev_cnt - e0 !== 0) begin errors++; $display("FAIL abort_events got=%0d exp=0", ev_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("FAIL abort_errs got=%0d exp=0", err_cnt - r0); end
    run_cw(10);
    repeat (4) @(posedge clk);
    checks++; if (ev_cnt - e0 !== 1) begin errors++; $display("FAIL post_rst_events got=%0d exp=1", ev_cnt - e0); end
    checks++; if (last_ev_dir !== 1'b1) begin errors++; $display("FAIL post_rst_dir got=%b exp=1", last_ev_dir); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cw_latency();
    test_ccw_cw_ccw();
    test_bounce();
    test_partial_and_jump();
    test_back_to_back();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL event_err_overlap got=%0d exp=0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
